mdr_host_driver: RTL

//  Host-side initiator for the MDR operand-load protocol. Accepts one command
//  (op, X, Y) on a valid/ready port and generates the MDR control-unit stimulus:
//  an active-low start pulse, then two active-low load pulses carrying X and Y.
//  It then waits for the unit's ready or error indication and returns one response.

---
 rtl/mdr_host_driver.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mdr_host_driver.sv
// Host-side initiator for the MDR operand-load protocol: one command in, a
// start pulse plus two operand load pulses out, then a single response back.
module mdr_host_driver #(
    parameter int DW      = 16,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [DW-1:0] cmd_x,
    input  logic [DW-1:0] cmd_y,
    output logic          mdr_start_n,
    output logic          mdr_load_n,
    output logic [1:0]    mdr_op,
    output logic [DW-1:0] mdr_data,
    input  logic          mdr_ready,
    input  logic          mdr_error,
    input  logic [DW-1:0] mdr_result,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_result,
    output logic          rsp_error,
    output logic          rsp_timeout
);

    localparam int CW = $clog2((TIMEOUT > GAP) ? TIMEOUT : GAP) + 1;
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        GAP1      = 3'd2,
        LOAD_X    = 3'd3,
        GAP2      = 3'd4,
        LOAD_Y    = 3'd5,
        WAIT_DONE = 3'd6,
        RESP      = 3'd7
    } state_t;

    state_t        state_r, state_nx_s;
    logic [CW-1:0] cnt_r, cnt_nx_s;
    logic [DW-1:0] y_r, y_nx_s;
    logic          cmd_ready_r, cmd_ready_nx_s;
    logic          start_n_r, start_n_nx_s;
    logic          load_n_r, load_n_nx_s;
    logic [1:0]    op_r, op_nx_s;
    logic [DW-1:0] data_r, data_nx_s;
    logic          rsp_valid_r, rsp_valid_nx_s;
    logic [DW-1:0] rsp_result_r, rsp_result_nx_s;
    logic          rsp_error_r, rsp_error_nx_s;
    logic          rsp_timeout_r, rsp_timeout_nx_s;

    // Next state and next registered output values; strobes are computed one
    // cycle early so they appear exactly in the state they belong to.
    always_comb begin
        state_nx_s       = state_r;
        cnt_nx_s         = cnt_r;
        y_nx_s           = y_r;
        cmd_ready_nx_s   = 1'b0;
        start_n_nx_s     = 1'b1;
        load_n_nx_s      = 1'b1;
        op_nx_s          = op_r;
        data_nx_s        = data_r;
        rsp_valid_nx_s   = rsp_valid_r;
        rsp_result_nx_s  = rsp_result_r;
        rsp_error_nx_s   = rsp_error_r;
        rsp_timeout_nx_s = rsp_timeout_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    state_nx_s   = START;
                    op_nx_s      = cmd_op;
                    y_nx_s       = cmd_y;
                    data_nx_s    = cmd_x;
                    start_n_nx_s = 1'b0;
                    cnt_nx_s     = '0;
                end else begin
                    cmd_ready_nx_s = 1'b1;
                end
            end
            START: begin
                state_nx_s = GAP1;
                cnt_nx_s   = '0;
            end
            GAP1: begin
                if (cnt_r == GAP_LAST) begin
                    state_nx_s  = LOAD_X;
                    load_n_nx_s = 1'b0;
                    cnt_nx_s    = '0;
                end else begin
                    cnt_nx_s = cnt_r + 1'b1;
                end
            end
            LOAD_X: begin
                state_nx_s = GAP2;
                data_nx_s  = y_r;
                cnt_nx_s   = '0;
            end
            GAP2: begin
                if (cnt_r == GAP_LAST) begin
                    state_nx_s  = LOAD_Y;
                    load_n_nx_s = 1'b0;
                    cnt_nx_s    = '0;
                end else begin
                    cnt_nx_s = cnt_r + 1'b1;
                end
            end
            LOAD_Y: begin
                state_nx_s = WAIT_DONE;
                cnt_nx_s   = '0;
            end
            WAIT_DONE: begin
                cnt_nx_s = cnt_r + 1'b1;
                // error outranks ready, which outranks timeout
                if (mdr_error) begin
                    state_nx_s       = RESP;
                    rsp_valid_nx_s   = 1'b1;
                    rsp_result_nx_s  = '0;
                    rsp_error_nx_s   = 1'b1;
                    rsp_timeout_nx_s = 1'b0;
                end else if (mdr_ready) begin
                    state_nx_s       = RESP;
                    rsp_valid_nx_s   = 1'b1;
                    rsp_result_nx_s  = mdr_result;
                    rsp_error_nx_s   = 1'b0;
                    rsp_timeout_nx_s = 1'b0;
                end else if (cnt_r == TO_LAST) begin
                    state_nx_s       = RESP;
                    rsp_valid_nx_s   = 1'b1;
                    rsp_result_nx_s  = '0;
                    rsp_error_nx_s   = 1'b0;
                    rsp_timeout_nx_s = 1'b1;
                end else begin
                    state_nx_s = WAIT_DONE;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx_s     = IDLE;
                    rsp_valid_nx_s = 1'b0;
                    cmd_ready_nx_s = 1'b1;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: begin
                state_nx_s     = IDLE;
                cmd_ready_nx_s = 1'b1;
            end
        endcase
    end

    // State, counters and all output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            y_r           <= '0;
            cmd_ready_r   <= 1'b1;
            start_n_r     <= 1'b1;
            load_n_r      <= 1'b1;
            op_r          <= 2'b00;
            data_r        <= '0;
            rsp_valid_r   <= 1'b0;
            rsp_result_r  <= '0;
            rsp_error_r   <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            cnt_r         <= cnt_nx_s;
            y_r           <= y_nx_s;
            cmd_ready_r   <= cmd_ready_nx_s;
            start_n_r     <= start_n_nx_s;
            load_n_r      <= load_n_nx_s;
            op_r          <= op_nx_s;
            data_r        <= data_nx_s;
            rsp_valid_r   <= rsp_valid_nx_s;
            rsp_result_r  <= rsp_result_nx_s;
            rsp_error_r   <= rsp_error_nx_s;
            rsp_timeout_r <= rsp_timeout_nx_s;
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign mdr_start_n = start_n_r;
    assign mdr_load_n  = load_n_r;
    assign mdr_op      = op_r;
    assign mdr_data    = data_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_result  = rsp_result_r;
    assign rsp_error   = rsp_error_r;
    assign rsp_timeout = rsp_timeout_r;

endmodule
